// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam int NREQ = 2;

    // ALU opcodes as carried on req_ctrl.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational RV32-style ALU shared by the arbiter.
// Shift amount is always b[4:0]; slt is a signed compare.
module alu_arbiter_alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             overflow;
    logic [4:0]       shamt;

    // Shared adder (ctrl[0] selects subtract) plus result mux.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        result   = '0;
        b_eff    = op[0] ? ~b : b;
        sum      = a + b_eff + {{(WIDTH-1){1'b0}}, op[0]};
        // Signed overflow of a - b: operand signs differ and the result sign differs from a.
        overflow = (a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);
        shamt    = b[4:0];
        unique case (op)
            ALU_ADD, ALU_SUB: result = sum;
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_XOR:          result = a ^ b;
            ALU_SLT:          result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ overflow};
            ALU_SLL:          result = a << shamt;
            ALU_SRL:          result = a >> shamt;
            default:          result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Sequence per op: IDLE (arbitrate/accept) -> EXEC (evaluate) -> RESP (hold until taken).
// Optional feature: define ALU_ARB_RR_EN for round-robin tie-breaking;
// otherwise requester 0 wins every tie (requester 1 may starve).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0] req_a,
    input  logic [NREQ-1:0][WIDTH-1:0] req_b,
    input  logic [NREQ-1:0][2:0]       req_ctrl,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_zero,
    output logic                       busy
);

    state_e           state_q, state_d;
    logic             grant;
    logic             accept;
    logic             rsp_fire;
    logic             owner_q;
    logic [WIDTH-1:0] a_q, b_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic [NREQ-1:0]  rsp_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

`ifdef ALU_ARB_RR_EN
    logic last_q;

    // Round-robin grant: on a tie pick the requester not granted last.
    always_comb begin
        grant = 1'b0;
        unique case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = 1'b0;
        endcase
    end

    // Last-grant pointer, moved on every accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       last_q <= 1'b1;
        else if (accept) last_q <= grant;
    end
`else
    // Fixed priority: requester 1 is granted only when requester 0 is idle.
    always_comb begin
        grant = (req_valid == 2'b10);
    end
`endif

    // Accept only in IDLE, only for the granted requester, only when it is valid.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && req_valid[grant])
            req_ready[grant] = 1'b1;
    end

    assign accept   = |req_ready;
    assign rsp_fire = |(rsp_valid_q & rsp_ready);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)   state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (rsp_fire) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Op registers: operands are sampled only at the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_ADD;
        end else if (accept) begin
            owner_q <= grant;
            a_q     <= req_a[grant];
            b_q     <= req_b[grant];
            op_q    <= alu_op_e'(req_ctrl[grant]);
        end
    end

    alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Response registers: loaded leaving EXEC, valid dropped on the owner's handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_valid_q <= NREQ'(1) << owner_q;
            result_q    <= alu_result;
            zero_q      <= alu_zero;
        end else if (rsp_fire) begin
            rsp_valid_q <= '0;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational RV32 ALU between two requesters (e.g. the integer datapath and an address/branch helper) on the core clock. Each requester gets a valid/ready request channel and its own response valid/ready channel. A small FSM controls the sequence: arbitrate, register the operands, evaluate the ALU, hold the result until the owning requester takes it. One operation is in flight at a time.

## Interface
- WIDTH, 32: operand/result width. Shift amount is always b[4:0].
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester request accept.
- req_a  in  2×WIDTH  packed [1:0][WIDTH-1:0]; operand a per requester.
- req_b  in  2×WIDTH  operand b per requester.
- req_ctrl  in  2×3  ALU op per requester: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- rsp_valid  out  2  one-hot; the response is for requester i.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  WIDTH  shared result bus, valid when either rsp_valid bit is set.
- rsp_zero  out  1  result == 0.
- busy  out  1  FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - req_ready[g] = 1 only for the granted index g, and only when req_valid[g] = 1.
  - On a handshake, capture a, b, ctrl and owner = g into op registers, then go to EXEC.
  - req_ready is 0 for the non-granted requester.
- EXEC: ALU evaluates the op registers. At the edge, capture result and zero into the response registers, then go to RESP.
- RESP: rsp_valid[owner] = 1. Stay in RESP until rsp_ready[owner] = 1, then go to IDLE. rsp_ready of the non-owner is ignored.
- req_ready is 0 in EXEC and RESP.
- Grant:
  - If only one req_valid bit is set, grant that requester.
  - If both are set, see Configuration.
- ALU arithmetic:
  - sum = a + (ctrl[0] ? ~b : b) + ctrl[0], modulo 2^WIDTH.
  - slt is signed: result = {0…, sum[MSB] ^ overflow}, where overflow is computed for the subtraction.
  - sll and srl are logical shifts by b[4:0].
- Operand and ctrl inputs are sampled only at the accept edge. Later changes have no effect.
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_result = 0, rsp_zero = 0, busy = 0.
  - owner = 0, RR last-grant pointer = 1.
- Reset mid-operation: an in-flight op in EXEC or RESP is discarded. No response is produced.

## Timing
- Request accepted at edge N. rsp_valid rises after edge N+1 (EXEC→RESP). Load-to-response latency is 2 cycles.
- Minimum spacing between accepts is 3 cycles: IDLE, EXEC, RESP with same-cycle rsp_ready.
- rsp_result, rsp_zero and rsp_valid are registered and stay stable in RESP until the handshake.
- req_ready is combinational from req_valid, state and the grant pointer. There is no combinational path from rsp_ready to req_ready.

## Configuration
- Macro: ALU_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are valid, grant the index not equal to the last-grant pointer. The pointer updates to g on each accept.
- Undefined: fixed priority. Requester 0 always wins a tie and the pointer logic is absent. Requester 1 can starve; this is documented and accepted.

## Structure
- Shared package alu_arb_pkg contains:
  - typedef enum for the ALU ops (ALU_ADD … ALU_SRL, 3 bits);
  - typedef enum for the FSM states;
  - constant NREQ = 2.
- One sub-module: the existing combinational alu, instantiated once and driven from the op registers.
- Grant logic stays inline.

## Test plan
- Req0 add a=5, b=7 → req_ready[0] at the same cycle. Two cycles later: rsp_valid = 01, rsp_result = 12, rsp_zero = 0.
- Req1 sub a=9, b=9 → rsp_valid = 10, rsp_result = 0, rsp_zero = 1. Then slt a=0xFFFFFFFF, b=1 → result = 1.
- Both requesters hold add requests continuously, with ALU_ARB_RR_EN defined → grants alternate 0, 1, 0, 1. Without the macro → all grants go to 0.
- rsp_ready[owner] held 0 for 5 cycles → rsp_valid and rsp_result remain constant, req_ready stays 0, busy = 1. After release: IDLE next cycle.
- rsp_ready asserted only on the non-owner → no handshake; FSM stays in RESP.
- Assert reset while in EXEC (sll a=1, b=4) → all outputs go to reset values immediately. No rsp_valid afterwards. The next request completes normally with owner and pointer at reset values.
